// File: rtl/tut4_verilog_regincr_collector_pkg.sv
// Shared types and widths for the regincr sample collector.
package tut4_verilog_regincr_collector_pkg;

    localparam int unsigned SUM_W = 12;
    localparam int unsigned MSG_W = 8;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/tut4_verilog_regincr_minmax_unit.sv
// Running min/max tracker for one batch of samples.
// Present only when TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN is defined.
`ifdef TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN
module tut4_verilog_regincr_minmax_unit
    import tut4_verilog_regincr_collector_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             update,
    input  logic [MSG_W-1:0] msg,
    output logic [MSG_W-1:0] min_val,
    output logic [MSG_W-1:0] max_val
);

    // Load restarts the batch; strict compares so ties keep the held value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_val <= '0;
            max_val <= '0;
        end else if (load) begin
            min_val <= msg;
            max_val <= msg;
        end else if (update) begin
            if (msg < min_val) begin
                min_val <= msg;
            end
            if (msg > max_val) begin
                max_val <= msg;
            end
        end
    end

endmodule
`endif

// File: rtl/tut4_verilog_regincr_sample_collector.sv
// Collects NSAMPLES valid/ready samples and presents their sum (and min/max
// when TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN is defined) as one result.
module tut4_verilog_regincr_sample_collector
    import tut4_verilog_regincr_collector_pkg::*;
#(
    parameter int unsigned NSAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [SUM_W-1:0] out_sum,
    output logic [MSG_W-1:0] out_min,
    output logic [MSG_W-1:0] out_max
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             xfer_c;
    logic             load_c;
    logic             accum_c;
    logic             in_rdy_next;
    logic             out_val_next;

    assign xfer_c = in_val && in_rdy;

    // Next-state and datapath control decode.
    always_comb begin
        state_next   = state;
        load_c       = 1'b0;
        accum_c      = 1'b0;
        count_inc    = count + CNT_W'(1);
        case (state)
            IDLE: begin
                if (xfer_c) begin
                    load_c     = 1'b1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (xfer_c) begin
                    accum_c = 1'b1;
                    if (count_inc == CNT_W'(NSAMPLES)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (out_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        in_rdy_next  = (state_next != DONE);
        out_val_next = (state_next == DONE);
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            in_rdy  <= 1'b1;
            out_val <= 1'b0;
            count   <= '0;
            out_sum <= '0;
        end else begin
            state   <= state_next;
            in_rdy  <= in_rdy_next;
            out_val <= out_val_next;
            if (load_c) begin
                count   <= CNT_W'(1);
                out_sum <= SUM_W'(in_msg);
            end else if (accum_c) begin
                count   <= count_inc;
                out_sum <= out_sum + SUM_W'(in_msg);
            end
        end
    end

`ifdef TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN
    tut4_verilog_regincr_minmax_unit u_minmax (
        .clk     (clk),
        .reset   (reset),
        .load    (load_c),
        .update  (accum_c),
        .msg     (in_msg),
        .min_val (out_min),
        .max_val (out_max)
    );
`else
    assign out_min = '0;
    assign out_max = '0;
`endif

endmodule

// File: tb/tb_tut4_verilog_regincr_sample_collector.sv
// Directed scoreboard bench for the sample collector (NSAMPLES=4 and 16).
module tb_tut4_verilog_regincr_sample_collector;

`ifdef TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    typedef struct {
        int unsigned sum;
        int unsigned mn;
        int unsigned mx;
    } result_t;

    logic        clk;
    logic        reset;
    logic [7:0]  in_msg;
    logic        in_val4, in_rdy4, out_val4, out_rdy4;
    logic [11:0] out_sum4;
    logic [7:0]  out_min4, out_max4;
    logic        in_val16, in_rdy16, out_val16, out_rdy16;
    logic [11:0] out_sum16;
    logic [7:0]  out_min16, out_max16;

    int compared;
    int mismatched;
    result_t sb[$];

    tut4_verilog_regincr_sample_collector #(.NSAMPLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_val(in_val4), .in_rdy(in_rdy4), .in_msg(in_msg),
        .out_val(out_val4), .out_rdy(out_rdy4),
        .out_sum(out_sum4), .out_min(out_min4), .out_max(out_max4)
    );

    tut4_verilog_regincr_sample_collector #(.NSAMPLES(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_val(in_val16), .in_rdy(in_rdy16), .in_msg(in_msg),
        .out_val(out_val16), .out_rdy(out_rdy16),
        .out_sum(out_sum16), .out_min(out_min16), .out_max(out_max16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic result_t mk(input int unsigned s, input int unsigned mn, input int unsigned mx);
        result_t r;
        r.sum = s;
        r.mn  = MM_EN ? mn : 0;
        r.mx  = MM_EN ? mx : 0;
        return r;
    endfunction

    // Present one sample for one clock edge; called and returns at negedge.
    task automatic feed(input bit big, input logic [7:0] m);
        if (big) in_val16 = 1'b1;
        else     in_val4  = 1'b1;
        in_msg = m;
        @(negedge clk);
        in_val4  = 1'b0;
        in_val16 = 1'b0;
    endtask

    task automatic gap();
        in_val4  = 1'b0;
        in_val16 = 1'b0;
        @(negedge clk);
    endtask

    // Wait (bounded) for a result handshake and compare it with the scoreboard head.
    task automatic expect_result(input string tag, input bit big, input int budget);
        bit got;
        result_t e;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (big ? (out_val16 && out_rdy16) : (out_val4 && out_rdy4)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_handshake"}, 32'(got), 32'd1);
        if (got) begin
            chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_sum"}, big ? 32'(out_sum16) : 32'(out_sum4), e.sum);
                chk({tag, "_min"}, big ? 32'(out_min16) : 32'(out_min4), e.mn);
                chk({tag, "_max"}, big ? 32'(out_max16) : 32'(out_max4), e.mx);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        in_msg     = '0;
        in_val4    = 1'b0;
        in_val16   = 1'b0;
        out_rdy4   = 1'b1;
        out_rdy16  = 1'b1;

        // Reset state
        #3 reset = 1'b0;
        #1;
        chk("rst_out_val", 32'(out_val4), 32'd0);
        chk("rst_sum", 32'(out_sum4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("rst_in_rdy", 32'(in_rdy4), 32'd1);
        chk("rst_min", 32'(out_min4), 32'd0);
        chk("rst_max", 32'(out_max4), 32'd0);
        chk("rst16_out_val", 32'(out_val16), 32'd0);
        chk("rst16_in_rdy", 32'(in_rdy16), 32'd1);

        // Basic batch, back-to-back
        sb.push_back(mk(18, 1, 9));
        feed(0, 8'd5);
        feed(0, 8'd1);
        feed(0, 8'd9);
        chk("basic_no_early_val", 32'(out_val4), 32'd0);
        feed(0, 8'd3);
        chk("basic_val_rise", 32'(out_val4), 32'd1);
        chk("basic_in_rdy_low", 32'(in_rdy4), 32'd0);
        expect_result("basic", 0, 4);
        @(negedge clk);
        chk("basic_idle_val", 32'(out_val4), 32'd0);
        chk("basic_idle_rdy", 32'(in_rdy4), 32'd1);

        // Backpressure: offered samples must be refused while held
        out_rdy4 = 1'b0;
        sb.push_back(mk(100, 10, 40));
        feed(0, 8'd10);
        feed(0, 8'd20);
        feed(0, 8'd30);
        feed(0, 8'd40);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_val", 32'(out_val4), 32'd1);
            chk("bp_in_rdy", 32'(in_rdy4), 32'd0);
            chk("bp_sum", 32'(out_sum4), 32'd100);
            in_val4 = 1'b1;
            in_msg  = 8'd99;
            @(negedge clk);
        end
        in_val4  = 1'b0;
        out_rdy4 = 1'b1;
        expect_result("bp", 0, 4);
        @(negedge clk);
        chk("bp_released", 32'(out_val4), 32'd0);

        // Gaps between samples
        sb.push_back(mk(21, 2, 8));
        feed(0, 8'd7);
        gap();
        gap();
        chk("gap_sum_hold", 32'(out_sum4), 32'd7);
        feed(0, 8'd2);
        gap();
        feed(0, 8'd8);
        chk("gap_no_early_val", 32'(out_val4), 32'd0);
        feed(0, 8'd4);
        expect_result("gap", 0, 4);
        @(negedge clk);

        // Reset mid-batch
        feed(0, 8'd50);
        feed(0, 8'd60);
        #2 reset = 1'b0;
        #1;
        chk("midrst_out_val", 32'(out_val4), 32'd0);
        chk("midrst_sum", 32'(out_sum4), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sb.push_back(mk(10, 1, 4));
        feed(0, 8'd1);
        feed(0, 8'd2);
        feed(0, 8'd3);
        feed(0, 8'd4);
        expect_result("midrst", 0, 4);
        @(negedge clk);

        // Reset while a result is pending discards it
        out_rdy4 = 1'b0;
        feed(0, 8'd9);
        feed(0, 8'd9);
        feed(0, 8'd9);
        feed(0, 8'd9);
        chk("donerst_pending", 32'(out_val4), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("donerst_out_val", 32'(out_val4), 32'd0);
        chk("donerst_in_rdy", 32'(in_rdy4), 32'd1);
        @(negedge clk);
        reset    = 1'b1;
        out_rdy4 = 1'b1;
        @(negedge clk);
        chk("donerst_no_result", 32'(out_val4), 32'd0);

        // Saturation with sixteen samples of 255
        sb.push_back(mk(4080, 255, 255));
        for (int i = 0; i < 15; i++) begin
            feed(1, 8'd255);
        end
        chk("sat_no_early_val", 32'(out_val16), 32'd0);
        feed(1, 8'd255);
        chk("sat_val_rise", 32'(out_val16), 32'd1);
        expect_result("sat", 1, 4);
        @(negedge clk);
        chk("sat_idle", 32'(out_val16), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tut4_verilog_regincr_sample_collector.md
TUT4_VERILOG_REGINCR_SAMPLE_COLLECTOR -- requirements
Module: tut4_verilog_regincr_sample_collector

Interface
REQ-001 SHALL have parameter NSAMPLES, default 4, the number of samples per batch; legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; asserted when 0.
REQ-004 SHALL have port in_val, input, 1 bit: upstream sample valid.
REQ-005 SHALL have port in_rdy, output, 1 bit: collector can accept a sample.
REQ-006 SHALL have port in_msg, input, 8 bits: unsigned sample, typically the registered incrementer output.
REQ-007 SHALL have port out_val, output, 1 bit: batch result valid.
REQ-008 SHALL have port out_rdy, input, 1 bit: downstream accepts result.
REQ-009 SHALL have port out_sum, output, 12 bits: unsigned sum of the batch.
REQ-010 SHALL have port out_min, output, 8 bits: minimum sample of the batch.
REQ-011 SHALL have port out_max, output, 8 bits: maximum sample of the batch.

Function
REQ-012 SHALL transfer a sample only in a cycle where in_val && in_rdy; a result transfers only when out_val && out_rdy.
REQ-013 SHALL implement FSM states IDLE, COLLECT and DONE.
REQ-014 IDLE: in_rdy=1, out_val=0; on a transfer: sum<=in_msg, min<=in_msg, max<=in_msg, count<=1, go to COLLECT.
REQ-015 COLLECT: in_rdy=1, out_val=0; on a transfer: sum<=sum+in_msg, min/max updated, count<=count+1; if the new count equals NSAMPLES, go to DONE.
REQ-016 COLLECT with in_val=0: hold all state; there is no timeout.
REQ-017 DONE: in_rdy=0, out_val=1; out_sum/out_min/out_max stable while out_val=1 && out_rdy=0.
REQ-018 DONE with out_rdy=1: go to IDLE next cycle. There is no bypass, so at least one bubble occurs between batches.
REQ-019 out_val SHALL rise exactly one cycle after the NSAMPLES-th sample transfer.
REQ-020 Sum SHALL be 12-bit with no overflow possible (16*255=4080); min/max comparisons are unsigned; ties keep the existing value.
REQ-021 in_rdy and out_val SHALL be pure functions of FSM state, with no combinational path from in_val or out_rdy.

Reset
REQ-022 Asserting reset (reset=0) SHALL immediately force IDLE, count=0, sum=0, min=0, max=0, out_val=0; in_rdy=1 after release.
REQ-023 Reset mid-batch or in DONE SHALL discard the partial or pending result; the first sample after release starts a new batch.

Configuration
REQ-024 Macro TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN: when defined, min/max tracking logic SHALL be present as in REQ-014/015.
REQ-025 Without TUT4_VERILOG_REGINCR_COLLECT_MINMAX_EN: min/max registers SHALL be absent, out_min=0 and out_max=0 constantly, and sum/handshake behaviour is unchanged.

Structure
REQ-026 Package tut4_verilog_regincr_collector_pkg SHALL hold the state enum (IDLE, COLLECT, DONE), SUM_W=12, MSG_W=8 and the count width constant (5 bits).
REQ-027 Sub-module tut4_verilog_regincr_minmax_unit SHALL hold the min/max registers and compare logic, instantiated only under the macro.

Verification
REQ-028 Reset, NSAMPLES=4, macro on: feed 5,1,9,3 back-to-back, out_rdy=1 -> out_val rises one cycle after the 4th sample; sum=18, min=1, max=9; IDLE the next cycle.
REQ-029 Backpressure: after a batch of 10,20,30,40, out_rdy=0 for 5 cycles -> out_val=1, in_rdy=0 and sum=100 held all 5 cycles; released on out_rdy=1.
REQ-030 Saturation, NSAMPLES=16: sixteen samples of 255 -> sum=4080, min=max=255.
REQ-031 Gaps: samples 7,_,_,2,_,8,4 (_ = in_val=0) -> sum=21, min=2, max=8; the gaps do not advance count.
REQ-032 Reset mid-batch: feed 50,60, pulse reset=0 asynchronously, then feed 1,2,3,4 -> sum=10, min=1, max=4; out_val=0 immediately on reset assertion.
REQ-033 Macro off: the REQ-028 stimulus -> sum=18, out_min=0 and out_max=0 throughout.
